step_dir_decoder: RTL and testbench

- Receiving end of the step/dir stepper-drive interface, used as the driver-side model and as the position feedback monitor.
- Synchronises step_in/dir_in, detects step rising edges and keeps a signed absolute step position.
- Measures the period between steps and flags overspeed, stall and position saturation to the control logic.
- Sits between the step generator output pins and the position/velocity supervision logic, in the 50 MHz clk domain.

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/step_dir_decoder_if.sv | 33 +++
 rtl/step_edge_sync.sv | 72 +++++++
 rtl/step_dir_decoder.sv | 128 ++++++++++++
 tb/tb_step_dir_decoder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
// Shared types and defaults for the step/dir decoder slice.
// Holds the decoder FSM state encoding, the default timing constants
// and the default position/period width typedefs.
package stepper_pkg;

  localparam int DEF_POS_W        = 24;
  localparam int DEF_PER_W        = 20;
  localparam int DEF_STALL_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int DEF_MIN_PERIOD   = 25;       // 2 MHz maximum step rate
  localparam int GLITCH_CYCLES    = 3;        // step high time needed by the filter

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    STALLED = 2'd2
  } dec_state_t;

  typedef logic signed [DEF_POS_W-1:0] pos_t;
  typedef logic        [DEF_PER_W-1:0] per_t;

endpackage

// File: rtl/step_dir_decoder_if.sv
// Bundle of the step/dir pins, decoder controls and the supervision outputs.
// master: the side driving the pins/controls; slave: the decoder itself.
interface step_dir_decoder_if
  import stepper_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int PER_W = DEF_PER_W
);

  logic                    step_in;
  logic                    dir_in;
  logic                    enable;
  logic                    clear_pos;
  logic signed [POS_W-1:0] pos;
  logic                    pos_valid;
  logic        [PER_W-1:0] period;
  logic                    period_valid;
  logic                    moving;
  logic                    stalled;
  logic                    step_err;
  logic                    sat;

  modport master (
    output step_in, dir_in, enable, clear_pos,
    input  pos, pos_valid, period, period_valid, moving, stalled, step_err, sat
  );

  modport slave (
    input  step_in, dir_in, enable, clear_pos,
    output pos, pos_valid, period, period_valid, moving, stalled, step_err, sat
  );

endinterface

// File: rtl/step_edge_sync.sv
// Step/dir input conditioning: 2-flop synchronisers, rising-edge detect on
// step and a direction bit aligned to the resulting event.
// Optional macro STEP_GLITCH_FILTER_EN: an event needs the synchronised step
// to be high for GLITCH_CYCLES consecutive clocks (dir delayed to match).
module step_edge_sync
  import stepper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  input  logic dir_in,
  output logic step_evt,
  output logic dir_evt
);

  logic step_s1, step_s2;
  logic dir_s1, dir_s2;

  // Metastability synchronisers for both pins, same depth so dir tracks step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
    end else begin
      step_s1 <= step_in;
      step_s2 <= step_s1;
      dir_s1  <= dir_in;
      dir_s2  <= dir_s1;
    end
  end

`ifdef STEP_GLITCH_FILTER_EN
  logic [1:0] high_cnt;
  logic       dir_s3, dir_s4;

  // Count consecutive high cycles (saturating past the threshold so a long
  // pulse fires once) and delay dir by the two extra cycles of filter latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt <= 2'd0;
      dir_s3   <= 1'b0;
      dir_s4   <= 1'b0;
    end else begin
      dir_s3 <= dir_s2;
      dir_s4 <= dir_s3;
      if (!step_s2)
        high_cnt <= 2'd0;
      else if (high_cnt != 2'(GLITCH_CYCLES))
        high_cnt <= high_cnt + 2'd1;
    end
  end

  assign step_evt = step_s2 && (high_cnt == 2'(GLITCH_CYCLES - 1));
  assign dir_evt  = dir_s4;
`else
  logic step_d;

  // Previous synchronised step level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      step_d <= 1'b0;
    else
      step_d <= step_s2;
  end

  assign step_evt = step_s2 & ~step_d;
  assign dir_evt  = dir_s2;
`endif

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: turns synchronised step events into a signed absolute
// position, measures the step period and flags overspeed, stall and
// position saturation. Build option STEP_GLITCH_FILTER_EN adds a
// minimum-width filter on step (see step_edge_sync).
module step_dir_decoder
  import stepper_pkg::*;
#(
  parameter int POS_W        = DEF_POS_W,
  parameter int PER_W        = DEF_PER_W,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD
)(
  input logic              clk,
  input logic              rst,
  step_dir_decoder_if.slave bus
);

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic        [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic        [PER_W-1:0] MIN_PER_C = PER_W'(MIN_PERIOD);
  localparam logic        [PER_W-1:0] STALL_C   = PER_W'(STALL_CYCLES);

  logic step_evt, dir_evt;

  dec_state_t              state;
  logic signed [POS_W-1:0] pos_r;
  logic                    pos_valid_r;
  logic        [PER_W-1:0] period_r;
  logic                    period_valid_r;
  logic        [PER_W-1:0] timer_r;
  logic                    moving_r, stalled_r, err_r, sat_r;

  // True when a step in direction up would leave the representable range
  function automatic logic pos_at_limit(input logic signed [POS_W-1:0] p,
                                        input logic up);
    return up ? (p == POS_MAX) : (p == POS_MIN);
  endfunction

  // One step in the given direction, holding at the range ends
  function automatic logic signed [POS_W-1:0] pos_sat_step(
      input logic signed [POS_W-1:0] p, input logic up);
    if (pos_at_limit(p, up))
      return p;
    return up ? p + POS_ONE : p - POS_ONE;
  endfunction

  // Free-running interval timer that sticks at all-ones instead of wrapping
  function automatic logic [PER_W-1:0] timer_inc(input logic [PER_W-1:0] t);
    return (&t) ? t : t + PER_ONE;
  endfunction

  step_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .step_in  (bus.step_in),
    .dir_in   (bus.dir_in),
    .step_evt (step_evt),
    .dir_evt  (dir_evt)
  );

  // Decoder FSM with position, period, timer and sticky flags all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pos_r          <= '0;
      pos_valid_r    <= 1'b0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      timer_r        <= '0;
      moving_r       <= 1'b0;
      stalled_r      <= 1'b0;
      err_r          <= 1'b0;
      sat_r          <= 1'b0;
    end else begin
      pos_valid_r    <= 1'b0;
      period_valid_r <= 1'b0;
      timer_r        <= timer_inc(timer_r);

      if (!bus.enable) begin
        // Disabled: steps ignored, FSM parked, measurements held
        state     <= IDLE;
        moving_r  <= 1'b0;
        stalled_r <= 1'b0;
      end else if (step_evt) begin
        timer_r <= PER_ONE;
        // Only a MOVING-to-MOVING interval is a meaningful period
        if (state == MOVING) begin
          period_r       <= timer_r;
          period_valid_r <= 1'b1;
        end
        state     <= MOVING;
        moving_r  <= 1'b1;
        stalled_r <= 1'b0;
        // A same-cycle clear swallows the position update
        if (!bus.clear_pos) begin
          pos_valid_r <= 1'b1;
          pos_r       <= pos_sat_step(pos_r, dir_evt);
          if (pos_at_limit(pos_r, dir_evt))
            sat_r <= 1'b1;
          if ((state == MOVING) && (timer_r < MIN_PER_C))
            err_r <= 1'b1;
        end
      end else if ((state == MOVING) && (timer_r >= STALL_C)) begin
        state     <= STALLED;
        moving_r  <= 1'b0;
        stalled_r <= 1'b1;
      end

      if (bus.clear_pos) begin
        pos_r <= '0;
        sat_r <= 1'b0;
        err_r <= 1'b0;
      end
    end
  end

  assign bus.pos          = pos_r;
  assign bus.pos_valid    = pos_valid_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.moving       = moving_r;
  assign bus.stalled      = stalled_r;
  assign bus.step_err     = err_r;
  assign bus.sat          = sat_r;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: a 24-bit and a 4-bit position instance share
// one step/dir stimulus; a time-based reference model predicts every output
// each cycle. Build with STEP_GLITCH_FILTER_EN to cover the filtered variant.
module tb_step_dir_decoder;
  import stepper_pkg::*;

  localparam int STALL = 2000;
  localparam int MINP  = 25;
`ifdef STEP_GLITCH_FILTER_EN
  localparam int LAT = 4;
  localparam int GW  = 3;
`else
  localparam int LAT = 2;
  localparam int GW  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b0, dir = 1'b0, en = 1'b1, clr = 1'b0;

  always #5 clk = ~clk;

  step_dir_decoder_if #(.POS_W(24), .PER_W(20)) bus24 ();
  step_dir_decoder_if #(.POS_W(4),  .PER_W(20)) bus4 ();

  assign bus24.step_in = step;  assign bus4.step_in = step;
  assign bus24.dir_in  = dir;   assign bus4.dir_in  = dir;
  assign bus24.enable  = en;    assign bus4.enable  = en;
  assign bus24.clear_pos = clr; assign bus4.clear_pos = clr;

  step_dir_decoder #(.POS_W(24), .PER_W(20), .STALL_CYCLES(STALL), .MIN_PERIOD(MINP))
    dut24 (.clk(clk), .rst(rst), .bus(bus24));
  step_dir_decoder #(.POS_W(4), .PER_W(20), .STALL_CYCLES(STALL), .MIN_PERIOD(MINP))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit d; } evt_t;
  evt_t q[$];

  int cyc = 0;
  int m_state = 0;          // 0 idle, 1 moving, 2 stalled
  int m_last = 0;
  int m_pos24 = 0, m_pos4 = 0;
  bit m_sat24 = 0, m_sat4 = 0, m_err = 0;
  int m_period = 0;
  bit exp_posv, exp_perv, evt, ed;
  int n_posv = 0, n_perv = 0;

  // Model advance and full output comparison once per cycle, 1 ns after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      m_state = 0; m_last = 0; m_pos24 = 0; m_pos4 = 0;
      m_sat24 = 0; m_sat4 = 0; m_err = 0; m_period = 0;
    end else begin
      evt = 0; ed = 0; exp_posv = 0; exp_perv = 0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        evt = 1; ed = q[0].d; void'(q.pop_front());
      end
      if (!en) begin
        m_state = 0;
      end else if (evt) begin
        if (m_state == 1) begin
          m_period = cyc - m_last;
          exp_perv = 1;
        end
        if (!clr) begin
          exp_posv = 1;
          if (m_state == 1 && (cyc - m_last) < MINP) m_err = 1;
          if (ed ? (m_pos24 == 8388607) : (m_pos24 == -8388608)) m_sat24 = 1;
          else m_pos24 += ed ? 1 : -1;
          if (ed ? (m_pos4 == 7) : (m_pos4 == -8)) m_sat4 = 1;
          else m_pos4 += ed ? 1 : -1;
        end
        m_state = 1;
        m_last = cyc;
      end else if (m_state == 1 && (cyc - m_last) >= STALL) begin
        m_state = 2;
      end
      if (clr) begin
        m_pos24 = 0; m_pos4 = 0; m_sat24 = 0; m_sat4 = 0; m_err = 0;
      end

      if (bus24.pos_valid) n_posv++;
      if (bus24.period_valid) n_perv++;

      check("pos_valid", bus24.pos_valid, exp_posv);
      check("pos_valid4", bus4.pos_valid, exp_posv);
      check("period_valid", bus24.period_valid, exp_perv);
      check("period", bus24.period, m_period);
      check("pos", $signed(bus24.pos), m_pos24);
      check("pos4", $signed(bus4.pos), m_pos4);
      check("moving", bus24.moving, (m_state == 1));
      check("stalled", bus24.stalled, (m_state == 2));
      check("step_err", bus24.step_err, m_err);
      check("sat", bus24.sat, m_sat24);
      check("sat4", bus4.sat, m_sat4);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_step(input bit d, input int width, input int gap);
    dir = d;
    step = 1'b1;
    if (width >= GW) q.push_back('{due: cyc + 1 + LAT, d: d});
    repeat (width) @(negedge clk);
    step = 1'b0;
    repeat (gap - width) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base_v, base_p, gap, wmax, r, pos_snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pos", $signed(bus24.pos), 0);
    check("rst_period", bus24.period, 0);
    check("rst_moving", bus24.moving, 0);
    check("rst_pos_valid", bus24.pos_valid, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 10 forward steps, 100 cycles apart
    base_p = n_perv;
    for (int i = 0; i < 10; i++) do_step(1'b1, 3, 100);
    check("s10_pos", $signed(bus24.pos), 10);
    check("s10_perv_cnt", n_perv - base_p, 9);
    check("s10_period", bus24.period, 100);
    check("s10_moving", bus24.moving, 1);
    check("s10_err", bus24.step_err, 0);

    // 5 up, 8 down
    pulse_clear();
    base_v = n_posv;
    for (int i = 0; i < 5; i++) do_step(1'b1, 3, 60);
    for (int i = 0; i < 8; i++) do_step(1'b0, 4, 60);
    check("updown_pos", $signed(bus24.pos), -3);
    check("updown_posv_cnt", n_posv - base_v, 13);

    // Overspeed
    do_step(1'b1, 3, 20);
    check("ovs_err_first", bus24.step_err, 0);
    do_step(1'b1, 3, 20);
    check("ovs_err_second", bus24.step_err, 1);
    do_step(1'b1, 3, 20);
    check("ovs_err_sticky", bus24.step_err, 1);
    pulse_clear();
    check("ovs_clr_pos", $signed(bus24.pos), 0);
    check("ovs_clr_err", bus24.step_err, 0);

    // Stall and recovery
    do_step(1'b1, 3, STALL + 50);
    check("stall_stalled", bus24.stalled, 1);
    check("stall_moving", bus24.moving, 0);
    base_p = n_perv;
    do_step(1'b1, 3, 50);
    check("unstall_pos", $signed(bus24.pos), 2);
    check("unstall_perv_cnt", n_perv - base_p, 0);
    check("unstall_moving", bus24.moving, 1);

    // Saturation of the 4-bit instance, then clear coincident with an event
    pulse_clear();
    for (int i = 0; i < 8; i++) do_step(1'b1, 3, 40);
    check("sat4_pos", $signed(bus4.pos), 7);
    check("sat4_flag", bus4.sat, 1);
    check("sat24_pos", $signed(bus24.pos), 8);
    base_v = n_posv;
    dir = 1'b1;
    step = 1'b1;
    q.push_back('{due: cyc + 1 + LAT, d: 1'b1});
    repeat (LAT) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    step = 1'b0;
    repeat (30) @(negedge clk);
    check("clrevt_pos4", $signed(bus4.pos), 0);
    check("clrevt_sat4", bus4.sat, 0);
    check("clrevt_posv_cnt", n_posv - base_v, 0);

    // Disabled decoder ignores steps
    en = 1'b0;
    for (int i = 0; i < 5; i++) do_step(1'b0, 3, 50);
    check("dis_pos", $signed(bus24.pos), 0);
    check("dis_moving", bus24.moving, 0);
    en = 1'b1;
    repeat (10) @(negedge clk);
    do_step(1'b0, 3, 50);
    check("reen_pos", $signed(bus24.pos), -1);

`ifdef STEP_GLITCH_FILTER_EN
    // Short pulse rejected, minimum-width pulse accepted
    pos_snap = $signed(bus24.pos);
    dir = 1'b1;
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch2_pos", $signed(bus24.pos), pos_snap);
    do_step(1'b1, 3, 40);
    check("glitch3_pos", $signed(bus24.pos), pos_snap + 1);
`endif

    // Randomized train
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r < 4)       gap = $urandom_range(6, 24);
      else if (r == 19) gap = STALL + $urandom_range(5, 100);
      else             gap = $urandom_range(30, 300);
      wmax = (gap - 3 < 8) ? gap - 3 : 8;
      do_step(1'($urandom_range(0, 1)), $urandom_range(3, wmax), gap);
    end

    // Asynchronous reset in the middle of a train
    pulse_clear();
    for (int i = 0; i < 3; i++) do_step(1'b1, 3, 30);
    dir = 1'b1;
    step = 1'b1;
    q.push_back('{due: cyc + 1 + LAT, d: 1'b1});
    @(negedge clk);
    rst = 1'b1;
    step = 1'b0;
    #1;
    check("arst_pos", $signed(bus24.pos), 0);
    check("arst_period", bus24.period, 0);
    check("arst_moving", bus24.moving, 0);
    check("arst_stalled", bus24.stalled, 0);
    check("arst_pos_valid", bus24.pos_valid, 0);
    check("arst_err", bus24.step_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_step(1'b1, 3, 50);
    check("post_rst_pos", $signed(bus24.pos), 1);
    check("post_rst_moving", bus24.moving, 1);

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
